// File: rtl/vad_score_compare.sv
`default_nettype none
// ============================================================================
// Module   : vad_score_compare
// Purpose  : Final speech / non-speech decision of the BNN VAD datapath, with
//            optional hangover that stretches speech decisions.
// Revision : 1.0 - initial release
// ============================================================================
module vad_score_compare #(
    parameter int W    = 16,
    parameter int HANG = 0,
    parameter int CW   = 8
) (
    input  logic           clk,
    input  logic           rst_n,       // active-high, synchronous
    input  logic           enable,
    input  logic [2*W-1:0] compare_in,
    output logic           result,
    output logic           valid,
    output logic           raw_result
);

    logic signed [W-1:0] w_score_speech;
    logic signed [W-1:0] w_score_noise;
    logic                w_raw;
    logic                r_raw;
    logic                r_valid;

    assign w_score_speech = compare_in[2*W-1:W];
    assign w_score_noise  = compare_in[W-1:0];
    // Direct signed compare cannot overflow; ties favour speech.
    assign w_raw          = (w_score_speech >= w_score_noise);

    always_ff @(posedge clk) begin
        if (rst_n) begin
            r_raw   <= 1'b0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= enable;
            if (enable) begin
                r_raw <= w_raw;
            end
        end
    end

    assign raw_result = r_raw;
    assign valid      = r_valid;

    generate
        if (HANG > 0 && CW > 0) begin : g_hang
            localparam logic [CW-1:0] c_hang = CW'(HANG);

            logic [CW-1:0] r_cnt;
            logic          r_result;

            // Counter only advances on enabled edges, so disabled cycles
            // do not shorten the hangover window.
            always_ff @(posedge clk) begin
                if (rst_n) begin
                    r_cnt    <= '0;
                    r_result <= 1'b0;
                end else if (enable) begin
                    if (w_raw) begin
                        r_cnt    <= c_hang;
                        r_result <= 1'b1;
                    end else if (r_cnt != '0) begin
                        r_cnt    <= r_cnt - 1'b1;
                        r_result <= 1'b1;
                    end else begin
                        r_result <= 1'b0;
                    end
                end
            end

            assign result = r_result;
        end else begin : g_no_hang
            assign result = r_raw;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_vad_score_compare.sv
`default_nettype none
// ============================================================================
// Module   : tb_vad_score_compare
// Purpose  : Directed self-checking bench for vad_score_compare (HANG 0/2/3).
// Revision : 1.0 - initial release
// ============================================================================
module tb_vad_score_compare;

    localparam int c_w = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst0, en0, rst2, en2, rst3, en3;
    logic [2*c_w-1:0] cin0, cin2, cin3;
    logic             result0, valid0, raw0;
    logic             result2, valid2, raw2;
    logic             result3, valid3, raw3;

    int n_vec = 0;
    int n_err = 0;

    vad_score_compare #(.W(c_w), .HANG(0), .CW(8)) u_dut0 (
        .clk(clk), .rst_n(rst0), .enable(en0), .compare_in(cin0),
        .result(result0), .valid(valid0), .raw_result(raw0)
    );
    vad_score_compare #(.W(c_w), .HANG(2), .CW(8)) u_dut2 (
        .clk(clk), .rst_n(rst2), .enable(en2), .compare_in(cin2),
        .result(result2), .valid(valid2), .raw_result(raw2)
    );
    vad_score_compare #(.W(c_w), .HANG(3), .CW(8)) u_dut3 (
        .clk(clk), .rst_n(rst3), .enable(en3), .compare_in(cin3),
        .result(result3), .valid(valid3), .raw_result(raw3)
    );

    function automatic logic [2*c_w-1:0] pk(input int s, input int n);
        logic [c_w-1:0] a;
        logic [c_w-1:0] b;
        a = c_w'(s);
        b = c_w'(n);
        return {a, b};
    endfunction

    task automatic check(input string tag, input logic got, input logic exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        int   s;
        int   n;
        logic exp;
    } vec_t;

    vec_t ext[4] = '{
        '{-32768, 32767, 1'b0},
        '{32767, -32768, 1'b1},
        '{-1, -1, 1'b1},
        '{-2, -1, 1'b0}
    };

    logic hang_exp[4]  = '{1'b1, 1'b1, 1'b1, 1'b0};
    logic hang_raw[4]  = '{1'b1, 1'b0, 1'b0, 1'b0};

    initial begin
        rst0 = 1'b1; en0 = 1'b1; cin0 = pk(10, -7);
        rst2 = 1'b1; en2 = 1'b0; cin2 = '0;
        rst3 = 1'b1; en3 = 1'b0; cin3 = '0;

        // Reset holds outputs low even with enable and a speech input
        for (int i = 0; i < 2; i++) begin
            step();
            check("rst_result", result0, 1'b0);
            check("rst_raw",    raw0,    1'b0);
            check("rst_valid",  valid0,  1'b0);
        end
        rst0 = 1'b0; rst2 = 1'b0; rst3 = 1'b0;

        // Basic decisions, HANG = 0
        cin0 = pk(10, 20); step();
        check("basic_noise", result0, 1'b0);
        check("basic_valid", valid0,  1'b1);
        cin0 = pk(5, 5); step();
        check("basic_tie", result0, 1'b1);
        check("tie_raw",   raw0,    1'b1);
        cin0 = pk(10, -7); step();
        check("basic_speech", result0, 1'b1);
        check("basic_valid2", valid0,  1'b1);

        // Enable gating
        en0 = 1'b0; cin0 = pk(10, 20);
        for (int i = 0; i < 3; i++) begin
            step();
            check("gate_hold",  result0, 1'b1);
            check("gate_valid", valid0,  1'b0);
        end
        en0 = 1'b1; step();
        check("gate_resume",  result0, 1'b0);
        check("gate_valid_1", valid0,  1'b1);

        // Signed extremes
        foreach (ext[i]) begin
            cin0 = pk(ext[i].s, ext[i].n); step();
            check("ext_result", result0, ext[i].exp);
            check("ext_raw",    raw0,    ext[i].exp);
        end

        // Unknown input while disabled must not disturb state
        cin0 = pk(1, 0); step();
        check("pre_x", result0, 1'b1);
        en0 = 1'b0; cin0 = 'x; step(); step();
        check("x_hold",  result0, 1'b1);
        check("x_raw",   raw0,    1'b1);
        check("x_valid", valid0,  1'b0);
        en0 = 1'b0; cin0 = '0;

        // Hangover, HANG = 2: raw 1,0,0,0 -> result 1,1,1,0
        en2 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cin2 = hang_raw[i] ? pk(10, -7) : pk(10, 20);
            step();
            check("hang_result", result2, hang_exp[i]);
            check("hang_raw",    raw2,    hang_raw[i]);
        end

        // Disabled cycle mid-hangover does not consume the counter
        cin2 = pk(10, -7); step();
        check("hgap_load", result2, 1'b1);
        cin2 = pk(10, 20); step();
        check("hgap_dec1", result2, 1'b1);
        en2 = 1'b0; step();
        check("hgap_hold",  result2, 1'b1);
        check("hgap_valid", valid2,  1'b0);
        en2 = 1'b1; step();
        check("hgap_dec2", result2, 1'b1);
        step();
        check("hgap_end", result2, 1'b0);
        en2 = 1'b0;

        // Reset mid-hangover, HANG = 3
        en3 = 1'b1; cin3 = pk(10, -7); step();
        check("hrst_load", result3, 1'b1);
        rst3 = 1'b1; step();
        check("hrst_result", result3, 1'b0);
        check("hrst_raw",    raw3,    1'b0);
        check("hrst_valid",  valid3,  1'b0);
        rst3 = 1'b0; cin3 = pk(10, 20); step();
        check("hrst_cleared", result3, 1'b0);
        check("hrst_valid1",  valid3,  1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
